// File: rtl/dram_rd_udp_pkg.sv
// Shared types and constants for the DRAM-read-to-UDP transmit path.
// The FSM encodings here are also the order of the header/payload phases.
package dram_rd_udp_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WAIT = 3'd1,
        REQ  = 3'd2,
        H0   = 3'd3,
        H1   = 3'd4,
        H2   = 3'd5,
        PAY  = 3'd6,
        GAP  = 3'd7
    } state_e;

    localparam int DATA_W         = 32;
    localparam int UPL_HDR_WORDS  = 3;
    localparam int BYTES_PER_WORD = 4;

    // UPL length field is a 16-bit byte count; wraps like the core expects.
    function automatic logic [15:0] byte_len(input logic [15:0] words);
        return words * 16'(BYTES_PER_WORD);
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO: rd_data shows the head word
// whenever empty is low, and rd_en consumes it.
module sync_fifo_fwft
    import dram_rd_udp_pkg::*;
#(
    parameter int AW = 9,
    parameter int DW = DATA_W
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    output logic [DW-1:0] rd_data,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);

    logic [DW-1:0] mem [2**AW];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;

    assign full    = count[AW];
    assign empty   = (count == '0);
    assign push    = wr_en && !full;
    assign pop     = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/dram_rd_udp_tx.sv
// Buffers read-engine words and slices each read transfer into UPL packets
// (3 header words + up to MAX_PKT_WORDS payload words) on UDP port 0.
module dram_rd_udp_tx
    import dram_rd_udp_pkg::*;
#(
    parameter int FIFO_AW       = 9,
    parameter int MAX_PKT_WORDS = 256
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        xfer_start,
    input  logic [31:0] xfer_words,
    input  logic [31:0] cfg_dst_ip,
    input  logic [15:0] cfg_src_port,
    input  logic [15:0] cfg_dst_port,
    output logic        xfer_busy,
    input  logic [31:0] buf_dout,
    input  logic        buf_we,
    output logic        buf_afull,
    output logic        ovf_err,
    output logic [31:0] pUdpSend_Data,
    output logic        pUdpSend_Request,
    input  logic        pUdpSend_Ack,
    output logic        pUdpSend_Enable
);

    localparam int DEPTH = 2**FIFO_AW;
    localparam int PKT_W = $clog2(MAX_PKT_WORDS + 1);
    localparam int CNT_W = FIFO_AW + 1;

    localparam logic [2:0] ST_IDLE = 3'(IDLE);
    localparam logic [2:0] ST_WAIT = 3'(WAIT);
    localparam logic [2:0] ST_REQ  = 3'(REQ);
    localparam logic [2:0] ST_H0   = 3'(H0);
    localparam logic [2:0] ST_H1   = 3'(H1);
    localparam logic [2:0] ST_H2   = 3'(H2);
    localparam logic [2:0] ST_PAY  = ST_H0 + 3'(UPL_HDR_WORDS);
    localparam logic [2:0] ST_GAP  = 3'(GAP);

    logic [2:0]       state;
    logic [31:0]      remaining;
    logic [PKT_W-1:0] pkt;
    logic [PKT_W-1:0] pkt_len;
    logic [PKT_W-1:0] pay_cnt;
    logic [31:0]      dst_ip;
    logic [15:0]      src_port;
    logic [15:0]      dst_port;

    logic [31:0]      fifo_dout;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_pop;

    logic             start_ok;
    logic             pkt_ready;
    logic             last_beat;

    sync_fifo_fwft #(
        .AW (FIFO_AW),
        .DW (32)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (buf_we),
        .wr_data (buf_dout),
        .rd_en   (fifo_pop),
        .rd_data (fifo_dout),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign buf_afull = (fifo_count >= CNT_W'(DEPTH - MAX_PKT_WORDS));
    assign start_ok  = xfer_start && (xfer_words != '0) && !xfer_busy && (state == ST_IDLE);

    always_comb begin
        pkt = PKT_W'(MAX_PKT_WORDS);
        if (remaining < 32'(MAX_PKT_WORDS)) begin
            pkt = remaining[PKT_W-1:0];
        end
    end

    // A packet is only requested once its whole payload is buffered, since
    // the UDP core gives no backpressure after Ack.
    assign pkt_ready = !fifo_empty && (32'(fifo_count) >= 32'(pkt));
    assign last_beat = (pay_cnt == pkt_len - PKT_W'(1));

    // Pop one cycle ahead of each payload beat; the data register adds the cycle back.
    assign fifo_pop = (state == ST_H2) || ((state == ST_PAY) && !last_beat);

    always_ff @(posedge clk) begin
        if (start_ok) begin
            dst_ip   <= cfg_dst_ip;
            src_port <= cfg_src_port;
            dst_port <= cfg_dst_port;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= ST_IDLE;
            remaining        <= '0;
            pkt_len          <= '0;
            pay_cnt          <= '0;
            xfer_busy        <= 1'b0;
            ovf_err          <= 1'b0;
            pUdpSend_Request <= 1'b0;
            pUdpSend_Enable  <= 1'b0;
            pUdpSend_Data    <= '0;
        end else begin
            // An overflow in the same cycle as a new transfer must not be lost.
            if (buf_we && fifo_full) begin
                ovf_err <= 1'b1;
            end else if (start_ok) begin
                ovf_err <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (start_ok) begin
                        remaining <= xfer_words;
                        xfer_busy <= 1'b1;
                        state     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (pkt_ready) begin
                        pkt_len          <= pkt;
                        pUdpSend_Request <= 1'b1;
                        state            <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (pUdpSend_Ack) begin
                        pUdpSend_Request <= 1'b0;
                        pUdpSend_Enable  <= 1'b1;
                        pUdpSend_Data    <= dst_ip;
                        state            <= ST_H0;
                    end
                end
                ST_H0: begin
                    pUdpSend_Data <= {src_port, dst_port};
                    state         <= ST_H1;
                end
                ST_H1: begin
                    pUdpSend_Data <= {16'd0, byte_len(16'(pkt_len))};
                    state         <= ST_H2;
                end
                ST_H2: begin
                    pUdpSend_Data <= fifo_dout;
                    pay_cnt       <= '0;
                    state         <= ST_PAY;
                end
                ST_PAY: begin
                    if (last_beat) begin
                        pUdpSend_Enable <= 1'b0;
                        pUdpSend_Data   <= '0;
                        remaining       <= remaining - 32'(pkt_len);
                        state           <= ST_GAP;
                    end else begin
                        pUdpSend_Data <= fifo_dout;
                        pay_cnt       <= pay_cnt + PKT_W'(1);
                    end
                end
                ST_GAP: begin
                    if (remaining == '0) begin
                        xfer_busy <= 1'b0;
                        state     <= ST_IDLE;
                    end else begin
                        state <= ST_WAIT;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dram_rd_udp_tx.sv
// Self-checking bench for dram_rd_udp_tx: a queue-based model of the FIFO and
// of the packet stream is compared against the UPL outputs every cycle.
`timescale 1ns/1ps
module tb_dram_rd_udp_tx;

    localparam int MAXP  = 256;
    localparam int DEPTH = 512;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        xfer_start = 1'b0;
    logic [31:0] xfer_words = '0;
    logic [31:0] cfg_dst_ip = '0;
    logic [15:0] cfg_src_port = '0;
    logic [15:0] cfg_dst_port = '0;
    logic        xfer_busy;
    logic [31:0] buf_dout = '0;
    logic        buf_we = 1'b0;
    logic        buf_afull;
    logic        ovf_err;
    logic [31:0] pUdpSend_Data;
    logic        pUdpSend_Request;
    logic        pUdpSend_Ack = 1'b0;
    logic        pUdpSend_Enable;

    always #5 clk = ~clk;

    dram_rd_udp_tx #(
        .FIFO_AW       (9),
        .MAX_PKT_WORDS (MAXP)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .xfer_start       (xfer_start),
        .xfer_words       (xfer_words),
        .cfg_dst_ip       (cfg_dst_ip),
        .cfg_src_port     (cfg_src_port),
        .cfg_dst_port     (cfg_dst_port),
        .xfer_busy        (xfer_busy),
        .buf_dout         (buf_dout),
        .buf_we           (buf_we),
        .buf_afull        (buf_afull),
        .ovf_err          (ovf_err),
        .pUdpSend_Data    (pUdpSend_Data),
        .pUdpSend_Request (pUdpSend_Request),
        .pUdpSend_Ack     (pUdpSend_Ack),
        .pUdpSend_Enable  (pUdpSend_Enable)
    );

    typedef struct { bit pay; logic [31:0] val; } beat_t;
    typedef struct { int len; bit last; } run_t;

    beat_t       exp_q[$];
    run_t        run_q[$];
    logic [31:0] m_fifo[$];
    bit          m_busy = 1'b0;
    bit          m_ovf = 1'b0;
    int          checks = 0;
    int          failures = 0;
    int          run_len = 0;
    int          cyc = 0;
    int          sz_prev = 0;
    bit          req_prev = 1'b0;
    bit          ack_prev = 1'b0;
    int          test_id = 0;
    int          probe = 0;
    int          ack_delay = 3;
    bit          ack_noise = 1'b0;

    function automatic int pkt_words(input int n, input int k);
        int rem;
        rem = n;
        for (int i = 0; i < k; i++) rem -= (rem > MAXP) ? MAXP : rem;
        return (rem > MAXP) ? MAXP : rem;
    endfunction

    function automatic logic [31:0] hdr_len(input int p);
        logic [15:0] b;
        b = 16'(p * 4);
        return {16'd0, b};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    task automatic queue_xfer(input int n, input logic [31:0] ip, input logic [31:0] ports);
        int rem;
        int p;
        rem = n;
        while (rem > 0) begin
            p = (rem > MAXP) ? MAXP : rem;
            exp_q.push_back(beat_t'{pay: 1'b0, val: ip});
            exp_q.push_back(beat_t'{pay: 1'b0, val: ports});
            exp_q.push_back(beat_t'{pay: 1'b0, val: hdr_len(p)});
            for (int i = 0; i < p; i++) exp_q.push_back(beat_t'{pay: 1'b1, val: 32'd0});
            run_q.push_back(run_t'{len: p + 3, last: (rem == p)});
            rem -= p;
        end
    endtask

    // Single compare process: check outputs produced by the last edge, then
    // fold the inputs the next edge will sample into the model.
    always @(negedge clk) begin
        beat_t       b;
        run_t        r;
        logic [31:0] e;
        bit          clear_busy;
        clear_busy = 1'b0;
        cyc++;
        if (cyc == 3) begin
            chk("pin_hdr16", hdr_len(16), 32'h40);
            chk("pin_split600_0", 32'(pkt_words(600, 0)), 32'd256);
            chk("pin_split600_1", 32'(pkt_words(600, 1)), 32'd256);
            chk("pin_split600_2", 32'(pkt_words(600, 2)), 32'd88);
            chk("pin_hdr352", hdr_len(pkt_words(600, 2)), 32'h160);
            chk("pin_hdr1", hdr_len(pkt_words(1, 0)), 32'h4);
        end
        if (!reset_n) begin
            chk("rst_req", 32'(pUdpSend_Request), 32'd0);
            chk("rst_en", 32'(pUdpSend_Enable), 32'd0);
            chk("rst_data", pUdpSend_Data, 32'd0);
            chk("rst_busy", 32'(xfer_busy), 32'd0);
            chk("rst_ovf", 32'(ovf_err), 32'd0);
            chk("rst_afull", 32'(buf_afull), 32'd0);
            exp_q.delete();
            run_q.delete();
            m_fifo.delete();
            m_busy  = 1'b0;
            m_ovf   = 1'b0;
            run_len = 0;
            sz_prev = 0;
        end else begin
            if (pUdpSend_Enable) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_enable", 32'(pUdpSend_Enable), 32'd0);
                end else begin
                    b = exp_q.pop_front();
                    if (b.pay) begin
                        if (m_fifo.size() == 0) begin
                            chk("payload_underrun", 32'(m_fifo.size()), 32'd1);
                        end else begin
                            e = m_fifo.pop_front();
                            chk("payload", pUdpSend_Data, e);
                        end
                    end else begin
                        chk("header", pUdpSend_Data, b.val);
                    end
                end
                if (test_id == 1 && run_len == 2) chk("t1_len_word", pUdpSend_Data, 32'h40);
                if (test_id == 1 && run_len == 3) chk("t1_first_pay", pUdpSend_Data, 32'h100);
                if (test_id == 1 && run_len == 18) chk("t1_last_pay", pUdpSend_Data, 32'h10F);
                run_len++;
            end else if (run_len > 0) begin
                if (run_q.size() == 0) begin
                    chk("unexpected_run", 32'(run_len), 32'd0);
                end else begin
                    r = run_q.pop_front();
                    chk("enable_run_len", 32'(run_len), 32'(r.len));
                    chk("busy_in_gap", 32'(xfer_busy), 32'd1);
                    clear_busy = r.last;
                end
                run_len = 0;
            end
            chk("busy", 32'(xfer_busy), 32'(m_busy));
            chk("ovf_err", 32'(ovf_err), 32'(m_ovf));
            chk("afull", 32'(buf_afull), 32'(m_fifo.size() >= DEPTH - MAXP));
            if (req_prev && !ack_prev) chk("req_hold", 32'(pUdpSend_Request), 32'd1);
            if (req_prev && ack_prev) chk("req_drop", 32'(pUdpSend_Request), 32'd0);
            if (pUdpSend_Request && !req_prev) begin
                if (run_q.size() == 0) begin
                    chk("unexpected_req", 32'(pUdpSend_Request), 32'd0);
                end else begin
                    chk("req_data_ready", 32'(sz_prev >= run_q[0].len - 3), 32'd1);
                end
                if (test_id == 3) chk("slow_req_at_256", 32'(sz_prev), 32'd256);
            end
            if (probe == 4) begin
                chk("ovf_lit", 32'(ovf_err), 32'd1);
                chk("afull_lit", 32'(buf_afull), 32'd1);
            end
            if (probe == 41) chk("ovf_cleared_lit", 32'(ovf_err), 32'd0);
            if (probe == 5) chk("zero_start_idle_lit", 32'(xfer_busy), 32'd0);
            sz_prev = m_fifo.size();

            if (xfer_start && xfer_words != 0 && !m_busy) begin
                m_busy = 1'b1;
                m_ovf  = 1'b0;
                queue_xfer(int'(xfer_words), cfg_dst_ip, {cfg_src_port, cfg_dst_port});
            end
            if (buf_we) begin
                if (m_fifo.size() < DEPTH) m_fifo.push_back(buf_dout);
                else m_ovf = 1'b1;
            end
            if (clear_busy) m_busy = 1'b0;
        end
        req_prev = pUdpSend_Request;
        ack_prev = pUdpSend_Ack;
    end

    // UDP core stand-in: grants Request after a delay, optional stray Acks.
    initial begin
        int cnt;
        bit seen;
        cnt  = 0;
        seen = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (pUdpSend_Request) begin
                if (!seen) begin
                    seen = 1'b1;
                    cnt  = (ack_delay >= 0) ? ack_delay : int'($urandom_range(0, 5));
                end
                if (cnt == 0) begin
                    pUdpSend_Ack = 1'b1;
                end else begin
                    cnt--;
                    pUdpSend_Ack = 1'b0;
                end
            end else begin
                seen = 1'b0;
                pUdpSend_Ack = ack_noise ? ($urandom_range(0, 3) == 0) : 1'b0;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog actual=timeout required=completion");
        $fatal(1, "watchdog expired");
    end

    task automatic push(input int n, input logic [31:0] base, input bit rnd, input int gap, input bit obey);
        @(posedge clk); #1;
        for (int i = 0; i < n; i++) begin
            while (obey && buf_afull) begin
                buf_we = 1'b0;
                @(posedge clk); #1;
            end
            buf_we   = 1'b1;
            buf_dout = rnd ? $urandom : base + 32'(i);
            @(posedge clk); #1;
            buf_we = 1'b0;
            repeat (gap) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic start(input logic [31:0] n);
        @(posedge clk); #1;
        xfer_start   = 1'b1;
        xfer_words   = n;
        cfg_dst_ip   = $urandom;
        cfg_src_port = 16'($urandom);
        cfg_dst_port = 16'($urandom);
        @(posedge clk); #1;
        xfer_start = 1'b0;
    endtask

    task automatic set_probe(input int id);
        @(posedge clk); #1;
        probe = id;
        @(posedge clk); #1;
        probe = 0;
    endtask

    task automatic wait_done();
        do @(posedge clk);
        while (!(exp_q.size() == 0 && run_q.size() == 0 && !xfer_busy));
        repeat (20) @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (5) @(posedge clk);
        #1 reset_n = 1'b1;

        test_id = 1;
        push(16, 32'h100, 1'b0, 0, 1'b1);
        start(16);
        wait_done();

        test_id   = 2;
        ack_delay = -1;
        ack_noise = 1'b1;
        fork
            push(600, 32'h2000, 1'b0, 0, 1'b1);
            begin
                repeat (10) @(posedge clk);
                start(600);
            end
        join
        wait_done();

        test_id = 3;
        start(256);
        push(256, 32'h3000, 1'b0, 3, 1'b1);
        wait_done();

        test_id = 4;
        push(513, 32'h0, 1'b1, 0, 1'b0);
        set_probe(4);
        start(512);
        probe = 41;
        @(posedge clk); #1;
        probe = 0;
        wait_done();

        test_id = 5;
        start(0);
        repeat (3) @(posedge clk);
        set_probe(5);
        push(20, 32'h5000, 1'b0, 0, 1'b1);
        start(20);
        repeat (2) @(posedge clk);
        start(100);
        wait_done();

        test_id = 6;
        for (int it = 0; it < 8; it++) begin
            int n;
            case (it)
                0:       n = 1;
                1:       n = 256;
                2:       n = 257;
                default: n = int'($urandom_range(2, 700));
            endcase
            fork
                push(n, 32'h0, 1'b1, int'($urandom_range(0, 2)), 1'b1);
                begin
                    repeat ($urandom_range(0, 30)) @(posedge clk);
                    start(32'(n));
                    repeat (2) @(posedge clk);
                    start($urandom_range(1, 50));
                end
            join
            wait_done();
        end

        test_id   = 7;
        ack_delay = 2;
        ack_noise = 1'b0;
        push(40, 32'h6000, 1'b0, 0, 1'b1);
        start(40);
        do @(posedge clk); while (!pUdpSend_Enable);
        repeat (8) @(posedge clk);
        #1 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        push(4, 32'h700, 1'b0, 0, 1'b1);
        start(4);
        wait_done();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
